wsel_decoder: RTL and testbench

Sequenced write-select generator for the DMAC register file: a parametrised, registered successor to the plain combinational address-to-one-hot decoder. It accepts a command (start address, beat count, mode) and emits one registered one-hot write strobe per enabled cycle. Supported modes are single write, incrementing burst with wrap-around, and broadcast to all registers. It sits between the DMAC control FSM and the register-file write enables.

---
 rtl/wsel_decoder_if.sv | 45 ++++
 rtl/wsel_decoder.sv | 130 +++++++++++++
 tb/tb_wsel_decoder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wsel_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : wsel_decoder_if
// Purpose  : Command / strobe bundle between the DMAC control FSM (master)
//            and the write-select generator (slave).
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Signals
//   start     master->slave  command request
//   mode[1:0] master->slave  00 single, 01 burst, 10 broadcast, 11 single
//   addr      master->slave  start address (AW bits)
//   len       master->slave  burst beat count (LW bits), 0 means 1
//   we        master->slave  beat enable
//   clear     master->slave  synchronous abort
//   q         slave->master  registered write strobe (2**AW bits)
//   cur_addr  slave->master  address of the next beat
//   busy      slave->master  command in progress
//   done      slave->master  one-cycle completion pulse
// ============================================================================
interface wsel_decoder_if #(
  parameter int AW = 3,
  parameter int LW = 4
);
  logic                 start;
  logic [1:0]           mode;
  logic [AW-1:0]        addr;
  logic [LW-1:0]        len;
  logic                 we;
  logic                 clear;
  logic [(1<<AW)-1:0]   q;
  logic [AW-1:0]        cur_addr;
  logic                 busy;
  logic                 done;

  modport master (
    output start, mode, addr, len, we, clear,
    input  q, cur_addr, busy, done
  );

  modport slave (
    input  start, mode, addr, len, we, clear,
    output q, cur_addr, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/wsel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : wsel_decoder
// Purpose  : Sequenced write-select generator. Accepts a command (address,
//            beat count, mode) and emits one registered one-hot write strobe
//            per enabled cycle: single write, wrapping incrementing burst,
//            or broadcast to every register.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   bus    slave modport of wsel_decoder_if (command in, strobe/status out)
// ============================================================================
module wsel_decoder #(
  parameter int AW = 3,
  parameter int LW = 4
) (
  input  wire logic       clk,
  input  wire logic       reset,
  wsel_decoder_if.slave   bus
);

  localparam int              c_SW         = 1 << AW;
  localparam logic [1:0]      c_MODE_BURST = 2'b01;
  localparam logic [1:0]      c_MODE_BCAST = 2'b10;
  localparam logic [LW:0]     c_REM_ONE    = {{LW{1'b0}}, 1'b1};
  localparam logic [c_SW-1:0] c_STRB_ONE   = {{(c_SW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state, w_state;
  logic [1:0]      r_mode,  w_mode;
  logic [AW-1:0]   r_addr,  w_addr;
  // One guard bit above LW so the largest len value needs no special case.
  logic [LW:0]     r_rem,   w_rem;
  logic [c_SW-1:0] r_q,     w_q;
  logic            r_busy,  w_busy;
  logic            r_done,  w_done;
  logic [c_SW-1:0] w_onehot;

  assign w_onehot = c_STRB_ONE << r_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mode  <= 2'b00;
      r_addr  <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_mode  <= w_mode;
      r_addr  <= w_addr;
      r_rem   <= w_rem;
      r_q     <= w_q;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  always_comb begin
    // Strobe and done are pulses: they drop unless a branch raises them.
    w_state = r_state;
    w_mode  = r_mode;
    w_addr  = r_addr;
    w_rem   = r_rem;
    w_q     = '0;
    w_busy  = r_busy;
    w_done  = 1'b0;

    if (bus.clear) begin
      // Abort wins over everything except reset; address is kept for debug.
      w_state = S_IDLE;
      w_busy  = 1'b0;
      w_rem   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_state = S_RUN;
            w_mode  = bus.mode;
            w_addr  = bus.addr;
            w_busy  = 1'b1;
            if (bus.mode == c_MODE_BURST && bus.len != '0) begin
              w_rem = {1'b0, bus.len};
            end else begin
              w_rem = c_REM_ONE;
            end
          end
        end
        S_RUN: begin
          if (bus.we) begin
            // Reserved mode 11 falls through to the single-write path.
            w_q = (r_mode == c_MODE_BCAST) ? {c_SW{1'b1}} : w_onehot;
            if (r_mode == c_MODE_BURST) begin
              w_addr = r_addr + 1'b1;
            end
            w_rem = r_rem - 1'b1;
            if (r_rem == c_REM_ONE) begin
              w_state = S_DONE;
            end
          end
        end
        S_DONE: begin
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end
        default: begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
        end
      endcase
    end
  end

  assign bus.q        = r_q;
  assign bus.cur_addr = r_addr;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_wsel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_wsel_decoder
// Purpose  : Self-checking bench for wsel_decoder: directed scenarios with
//            literal expectations plus randomized traffic compared every
//            cycle against a queue-based command model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wsel_decoder;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  wsel_decoder_if #(.AW(3), .LW(4)) bus ();

  wsel_decoder #(.AW(3), .LW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a command becomes the list of strobes it must produce; each
  // enabled RUN cycle pops one, and one extra edge after the list empties
  // delivers the done pulse.
  logic [7:0] mq[$];
  logic       m_active;
  logic       m_fin;
  logic       m_burst;
  logic [2:0] m_base;
  logic [2:0] m_cur;
  int         m_beats;
  logic [7:0] e_q;
  logic       e_done;

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_fin    = 1'b0;
    m_burst  = 1'b0;
    m_base   = 3'd0;
    m_cur    = 3'd0;
    m_beats  = 0;
    e_q      = 8'h00;
    e_done   = 1'b0;
  endtask

  task automatic model_step();
    int         n;
    logic [2:0] a;
    e_q    = 8'h00;
    e_done = 1'b0;
    if (bus.clear) begin
      m_active = 1'b0;
      m_fin    = 1'b0;
      mq.delete();
    end else if (!m_active) begin
      if (bus.start) begin
        n = (bus.mode == 2'b01) ? ((bus.len == 0) ? 1 : int'(bus.len)) : 1;
        for (int i = 0; i < n; i++) begin
          a = 3'((int'(bus.addr) + i) % 8);
          mq.push_back((bus.mode == 2'b10) ? 8'hFF : (8'h01 << a));
        end
        m_active = 1'b1;
        m_fin    = 1'b0;
        m_burst  = (bus.mode == 2'b01);
        m_base   = bus.addr;
        m_cur    = bus.addr;
        m_beats  = 0;
      end
    end else if (m_fin) begin
      e_done   = 1'b1;
      m_active = 1'b0;
      m_fin    = 1'b0;
    end else if (bus.we) begin
      e_q     = mq.pop_front();
      m_beats = m_beats + 1;
      if (m_burst) m_cur = 3'((int'(m_base) + m_beats) % 8);
      if (mq.size() == 0) m_fin = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: model follows the edge, then all outputs are compared on the
  // falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_q",        32'(bus.q),        32'(e_q));
    chk("model_cur_addr", 32'(bus.cur_addr), 32'(m_cur));
    chk("model_busy",     32'(bus.busy),     32'(m_active));
    chk("model_done",     32'(bus.done),     32'(e_done));
  endtask

  task automatic issue(input logic [1:0] m, input logic [2:0] a, input logic [3:0] l);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.addr  = a;
    bus.len   = l;
    cyc();
    bus.start = 1'b0;
    chk("accept_no_strobe", 32'(bus.q), 32'h0);
    chk("accept_busy",      32'(bus.busy), 32'h1);
  endtask

  logic [7:0] seq_wrap[4]  = '{8'h40, 8'h80, 8'h01, 8'h02};
  logic [7:0] seq_stall[5] = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h04};
  logic       we_stall[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] seq_abort[3] = '{8'h02, 8'h04, 8'h08};

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 2'b00;
    bus.addr  = 3'd0;
    bus.len   = 4'd0;
    bus.we    = 1'b1;
    bus.clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_q",    32'(bus.q),        32'h0);
    chk("reset_addr", 32'(bus.cur_addr), 32'h0);
    chk("reset_busy", 32'(bus.busy),     32'h0);
    chk("reset_done", 32'(bus.done),     32'h0);

    // Single write, len ignored.
    issue(2'b00, 3'd5, 4'd9);
    cyc();
    chk("single_q", 32'(bus.q), 32'h20);
    cyc();
    chk("single_done", 32'(bus.done), 32'h1);
    chk("single_q0",   32'(bus.q), 32'h0);
    chk("single_busy", 32'(bus.busy), 32'h0);
    chk("single_addr", 32'(bus.cur_addr), 32'h5);

    // Wrapping burst, accepted on the edge right after done.
    issue(2'b01, 3'd6, 4'd4);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("wrap_q", 32'(bus.q), 32'(seq_wrap[i]));
      chk("wrap_nodone", 32'(bus.done), 32'h0);
    end
    cyc();
    chk("wrap_done", 32'(bus.done), 32'h1);
    chk("wrap_addr", 32'(bus.cur_addr), 32'h2);
    cyc();

    // Stall pattern.
    issue(2'b01, 3'd0, 4'd3);
    for (int i = 0; i < 5; i++) begin
      bus.we = we_stall[i];
      cyc();
      chk("stall_q", 32'(bus.q), 32'(seq_stall[i]));
      chk("stall_nodone", 32'(bus.done), 32'h0);
    end
    bus.we = 1'b1;
    cyc();
    chk("stall_done", 32'(bus.done), 32'h1);
    cyc();
    chk("stall_done_once", 32'(bus.done), 32'h0);

    // Broadcast, then burst with len=0.
    issue(2'b10, 3'd2, 4'd7);
    cyc();
    chk("bcast_q", 32'(bus.q), 32'hFF);
    cyc();
    chk("bcast_done", 32'(bus.done), 32'h1);
    issue(2'b01, 3'd3, 4'd0);
    cyc();
    chk("len0_q", 32'(bus.q), 32'h08);
    cyc();
    chk("len0_done", 32'(bus.done), 32'h1);
    cyc();

    // Start during RUN ignored, then clear aborts.
    issue(2'b01, 3'd1, 4'd8);
    for (int i = 0; i < 3; i++) begin
      bus.start = (i == 1);
      bus.mode  = 2'b10;
      bus.addr  = 3'd7;
      cyc();
      chk("abort_q", 32'(bus.q), 32'(seq_abort[i]));
    end
    bus.start = 1'b0;
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    chk("clear_q",    32'(bus.q), 32'h0);
    chk("clear_busy", 32'(bus.busy), 32'h0);
    chk("clear_done", 32'(bus.done), 32'h0);
    issue(2'b00, 3'd4, 4'd0);
    cyc();
    chk("post_clear_q", 32'(bus.q), 32'h10);
    cyc();
    chk("post_clear_done", 32'(bus.done), 32'h1);

    // Asynchronous reset between edges.
    issue(2'b01, 3'd2, 4'd8);
    cyc();
    cyc();
    chk("pre_reset_q", 32'(bus.q), 32'h08);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("async_q",    32'(bus.q), 32'h0);
    chk("async_busy", 32'(bus.busy), 32'h0);
    chk("async_done", 32'(bus.done), 32'h0);
    chk("async_addr", 32'(bus.cur_addr), 32'h0);
    #1 reset = 1'b0;
    issue(2'b01, 3'd7, 4'd2);
    cyc();
    chk("post_reset_q0", 32'(bus.q), 32'h80);
    cyc();
    chk("post_reset_q1", 32'(bus.q), 32'h01);
    cyc();
    chk("post_reset_done", 32'(bus.done), 32'h1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      bus.mode  = 2'($urandom_range(0, 3));
      bus.addr  = 3'($urandom_range(0, 7));
      bus.len   = 4'($urandom_range(0, 15));
      bus.we    = ($urandom_range(0, 3) != 0);
      bus.clear = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("rand_async_q", 32'(bus.q), 32'h0);
        #1 reset = 1'b0;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
